uart_pkt_parser: RTL

Receive-side framing stage that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle `rx_done` strobe and `rx_data` byte, and hunts for frames of the form SOF, LEN, payload, CHK. Each frame is buffered and its checksum validated. Good payloads are released as a valid/ready byte stream with a last-byte marker; bad frames are discarded and reported on one-cycle error strobes.

---
 rtl/uart_pkt_parser.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser
//
// Receive-side framing stage placed after a UART receiver. Hunts for frames of the form
// SOF, LEN, payload[LEN], CHK. The checksum is LEN plus all payload bytes, mod 256.
// Each payload is buffered, and the checksum is checked when CHK arrives. A good payload is
// then released as a valid/ready byte stream, with out_last marking the final byte. A bad
// frame is dropped and reported on a one-cycle error strobe.
//
// Optional feature: define UART_PKT_TIMEOUT_EN to build an inter-byte timeout. The timeout
// runs in the LEN, DATA and CHK states and reports on tmo_err. With the macro undefined,
// no timeout counter is built and tmo_err is tied low.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rx_data    received byte, qualified by rx_done
//   rx_done    one-cycle strobe: rx_data holds a new byte
//   out_data   payload byte (0 when out_valid is low)
//   out_valid  out_data is valid
//   out_last   out_data is the final payload byte of the frame
//   out_ready  downstream accepts the byte
//   busy       parser is anywhere but HUNT
//   chk_err    one-cycle strobe: checksum mismatch
//   len_err    one-cycle strobe: LEN is 0 or above MAX_LEN
//   ovr_err    one-cycle strobe: byte arrived while sending, and it was dropped
//   tmo_err    one-cycle strobe: inter-byte timeout (0 without UART_PKT_TIMEOUT_EN)

module uart_pkt_parser #(
   parameter int unsigned MAX_LEN        = 16,
   parameter logic [7:0]  SOF_BYTE       = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       busy,
   output logic       chk_err,
   output logic       len_err,
   output logic       ovr_err,
   output logic       tmo_err
);

   localparam int unsigned CW = $clog2(MAX_LEN + 1);
   // Buffer address width; cnt/rd_idx never address beyond MAX_LEN-1 when used as an index.
   localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {
      StHunt,
      StLen,
      StData,
      StChk,
      StSend
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   len_q, len_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   rd_idx_q, rd_idx_d;
   logic [7:0]      sum_q, sum_d;
   logic            chk_err_q, chk_err_d;
   logic            len_err_q, len_err_d;
   logic            ovr_err_q, ovr_err_d;

   logic [7:0]      pay_mem [MAX_LEN];
   logic            mem_we;
   logic            len_ok;
   logic            last_byte;

   // LEN is legal when it is in 1..MAX_LEN (unsigned compare).
   assign len_ok    = (rx_data != 8'h00) && (32'(rx_data) <= MAX_LEN);
   assign last_byte = (rd_idx_q == (len_q - CW'(1)));

`ifdef UART_PKT_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            tmo_err_q, tmo_err_d;
   logic            timed;
   logic            tmo_hit;

   assign timed   = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
   // A byte arriving in the limit cycle wins over the timeout.
   assign tmo_hit = timed && !rx_done && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_cnt_d = '0;
      if (timed && !rx_done && !tmo_hit) begin
         tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign tmo_err = tmo_err_q;
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign tmo_err        = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      rd_idx_d  = rd_idx_q;
      sum_d     = sum_q;
      chk_err_d = 1'b0;
      len_err_d = 1'b0;
      ovr_err_d = 1'b0;
      mem_we    = 1'b0;
`ifdef UART_PKT_TIMEOUT_EN
      tmo_err_d = 1'b0;
`endif

      unique case (state_q)
         StHunt: begin
            if (rx_done && (rx_data == SOF_BYTE)) begin
               state_d = StLen;
            end
         end

         StLen: begin
            // A SOF value here is just a length byte; there is no resync.
            if (rx_done) begin
               if (len_ok) begin
                  len_d   = CW'(rx_data);
                  sum_d   = rx_data;
                  cnt_d   = '0;
                  state_d = StData;
               end else begin
                  len_err_d = 1'b1;
                  state_d   = StHunt;
               end
            end
         end

         StData: begin
            if (rx_done) begin
               mem_we = 1'b1;
               sum_d  = sum_q + rx_data;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == (len_q - CW'(1))) begin
                  state_d = StChk;
               end
            end
         end

         StChk: begin
            if (rx_done) begin
               if (rx_data == sum_q) begin
                  rd_idx_d = '0;
                  state_d  = StSend;
               end else begin
                  chk_err_d = 1'b1;
                  state_d   = StHunt;
               end
            end
         end

         StSend: begin
            // Incoming bytes cannot be buffered while draining; drop and report.
            if (rx_done) begin
               ovr_err_d = 1'b1;
            end
            if (out_ready) begin
               rd_idx_d = rd_idx_q + CW'(1);
               if (last_byte) begin
                  state_d = StHunt;
               end
            end
         end

         default: begin
            state_d = StHunt;
         end
      endcase

`ifdef UART_PKT_TIMEOUT_EN
      // Only reachable in LEN/DATA/CHK with no byte this cycle, so no other strobe collides.
      if (tmo_hit) begin
         state_d   = StHunt;
         tmo_err_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StHunt;
         len_q     <= '0;
         cnt_q     <= '0;
         rd_idx_q  <= '0;
         sum_q     <= '0;
         chk_err_q <= 1'b0;
         len_err_q <= 1'b0;
         ovr_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         rd_idx_q  <= rd_idx_d;
         sum_q     <= sum_d;
         chk_err_q <= chk_err_d;
         len_err_q <= len_err_d;
         ovr_err_q <= ovr_err_d;
      end
   end

   // Payload buffer: contents are don't-care after reset, so no reset term.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         pay_mem[cnt_q[IW-1:0]] <= rx_data;
      end
   end

   assign busy      = (state_q != StHunt);
   assign out_valid = (state_q == StSend);
   // Gated so that out_data and out_last read 0 whenever nothing is being offered.
   assign out_data  = out_valid ? pay_mem[rd_idx_q[IW-1:0]] : 8'h00;
   assign out_last  = out_valid && last_byte;
   assign chk_err   = chk_err_q;
   assign len_err   = len_err_q;
   assign ovr_err   = ovr_err_q;

endmodule
